cmo_req_arbiter: RTL and testbench

- Shares the single L1 D-Cache CMO request/response port between NR_PORTS CMO requesters, e.g. the CMO functional unit and the flush/debug controller.
- Arbitrates requests round-robin and locks the grant until the cache accepts.
- Records the source port of every accepted request in an in-order tracking FIFO and routes each cache ack back to its originator.
- Sits between the requesters and the D-Cache CMO port of the cache subsystem.

---
 rtl/cmo_req_arbiter_pkg.sv | 37 +++
 rtl/cmo_arb_rr.sv | 45 ++++
 rtl/cmo_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_cmo_req_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cmo_req_arbiter_pkg.sv
// Shared types for the CMO request arbiter.
// - cmo_req_t / cmo_resp_t : CMO request/response bundles exchanged with the
//   D-Cache CMO port.
// - cmo_arb_state_t        : grant state of the arbiter (idle / locked).
// - CMO_ARB_MAX_PORTS      : largest supported requester count.
package cmo_req_arbiter_pkg;

  localparam int unsigned CMO_ARB_MAX_PORTS = 8;
  localparam int unsigned TRANS_ID_BITS     = 4;
  localparam int unsigned CMO_ADDR_W        = 64;

  typedef enum logic [3:0] {
    CMO_CLEAN = 4'd0,
    CMO_FLUSH = 4'd1,
    CMO_INVAL = 4'd2,
    CMO_ZERO  = 4'd3
  } cmo_t;

  typedef struct packed {
    logic                     req;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [CMO_ADDR_W-1:0]    address;
    cmo_t                     cmo_op;
  } cmo_req_t;

  typedef struct packed {
    logic                     req_ready;
    logic                     ack;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } cmo_resp_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } cmo_arb_state_t;

endpackage

// File: rtl/cmo_arb_rr.sv
// Combinational winner select for the CMO arbiter.
// Picks the first asserted bit of req_i at or after ptr_i, wrapping from
// NR_PORTS-1 back to 0.
// Build option: CMO_ARB_FIXED_PRIO_EN -> ptr_i is ignored, lowest index wins.
// Ports:
//   req_i    : per-port request vector
//   ptr_i    : round-robin start position
//   gnt_oh_o : one-hot winner
//   idx_o    : winner index
//   valid_o  : at least one request present
module cmo_arb_rr #(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned IDX_W    = 1
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [NR_PORTS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    k        = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
`ifdef CMO_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = (int'(ptr_i) + i) % NR_PORTS;
`endif
      if (!found && req_i[k]) begin
        found       = 1'b1;
        idx_o       = IDX_W'(k);
        gnt_oh_o[k] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cmo_req_arbiter.sv
// Shares the single D-Cache CMO port between NR_PORTS requesters.
// Round-robin grant that stays locked on one port until the cache accepts,
// plus an in-order tracking FIFO of accepted source ports used to route
// each cache ack back to the requester that issued it.
// Build option: CMO_ARB_FIXED_PRIO_EN -> fixed priority (lowest index wins),
// round-robin pointer held at 0.
// Handshake: a request transfers in the cycle where cmo_dc_req_o.req and
// cmo_dc_resp_i.req_ready are both 1; the granted requester must hold req
// and payload stable until then. Acks are single-cycle and arrive in
// request order.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   req_i / resp_o  : per-requester request / response
//   cmo_dc_req_o    : request to the D-Cache
//   cmo_dc_resp_i   : response from the D-Cache
//   busy_o          : entries outstanding or a grant is locked
//   spurious_ack_o  : ack seen with nothing outstanding (1-cycle pulse)
module cmo_req_arbiter
  import cmo_req_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  cmo_req_t  [NR_PORTS-1:0] req_i,
  output cmo_resp_t [NR_PORTS-1:0] resp_o,
  output cmo_req_t                 cmo_dc_req_o,
  input  cmo_resp_t                cmo_dc_resp_i,
  output logic                     busy_o,
  output logic                     spurious_ack_o
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  cmo_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]    lock_idx_q;
  logic [IDX_W-1:0]    rr_ptr;
  logic [NR_PORTS-1:0] req_vec, arb_oh, grant_oh;
  logic [IDX_W-1:0]    arb_idx, grant_idx;
  logic                arb_valid, grant_valid, accept, pop;
  logic                fifo_full, fifo_empty;

  logic [IDX_W-1:0]    fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    head_idx;

  always_comb begin
    for (int unsigned k = 0; k < NR_PORTS; k++) req_vec[k] = req_i[k].req;
  end

  cmo_arb_rr #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i    (req_vec),
    .ptr_i    (rr_ptr),
    .gnt_oh_o (arb_oh),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = fifo_mem[rd_ptr_q];

  // Grant / lock FSM. Everything is gated by rst_ni so that outputs read 0
  // during the reset cycle even while requests are held.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_idx   = arb_idx;
    grant_oh    = arb_oh;
    unique case (state_q)
      ARB_IDLE: begin
        // Fullness uses the registered count only: an ack in this cycle
        // frees the slot for the next cycle, keeping ack off the req path.
        grant_valid = rst_ni && !fifo_full && arb_valid;
        if (grant_valid && !cmo_dc_resp_i.req_ready) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        grant_idx   = lock_idx_q;
        grant_oh    = NR_PORTS'(1) << lock_idx_q;
        grant_valid = rst_ni && req_i[lock_idx_q].req;
        // Leave on acceptance, or when the owner withdraws its request.
        if (!req_i[lock_idx_q].req || cmo_dc_resp_i.req_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign accept = grant_valid && cmo_dc_resp_i.req_ready;
  assign pop    = rst_ni && cmo_dc_resp_i.ack && !fifo_empty;

  always_comb begin
    cmo_dc_req_o = grant_valid ? req_i[grant_idx] : '0;
    resp_o       = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      resp_o[k].req_ready = grant_valid && grant_oh[k] && cmo_dc_resp_i.req_ready;
      if (pop && (head_idx == IDX_W'(k))) begin
        resp_o[k].ack      = 1'b1;
        resp_o[k].trans_id = cmo_dc_resp_i.trans_id;
      end
    end
  end

  assign spurious_ack_o = rst_ni && cmo_dc_resp_i.ack && fifo_empty;
  assign busy_o         = rst_ni && (!fifo_empty || (state_q == ARB_LOCKED));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ARB_IDLE) && grant_valid && !accept) lock_idx_q <= grant_idx;
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr_q] <= grant_idx;
  end

`ifdef CMO_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (grant_idx == IDX_W'(NR_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

endmodule

// File: tb/tb_cmo_req_arbiter.sv
// Randomized bench for cmo_req_arbiter against a queue-based reference model.
module tb_cmo_req_arbiter;
  import cmo_req_arbiter_pkg::*;

  localparam int NR_PORTS = 2;
  localparam int MAX_OUT  = 4;
  localparam int TID_W    = TRANS_ID_BITS;
  localparam int SB_W     = 8 + TID_W;
  localparam int N_CYC    = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cmo_req_t  [NR_PORTS-1:0] req_i;
  cmo_resp_t [NR_PORTS-1:0] resp_o;
  cmo_req_t                 cmo_dc_req_o;
  cmo_resp_t                cmo_dc_resp_i;
  logic                     busy_o;
  logic                     spurious_ack_o;

  cmo_req_arbiter #(
    .NR_PORTS        (NR_PORTS),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .resp_o         (resp_o),
    .cmo_dc_req_o   (cmo_dc_req_o),
    .cmo_dc_resp_i  (cmo_dc_resp_i),
    .busy_o         (busy_o),
    .spurious_ack_o (spurious_ack_o)
  );

  // ---------------- scoreboard / model state ----------------
  logic [SB_W-1:0] exp_q[$];      // {port, trans_id} of accepted, unacked CMOs
  int              lock_port = -1;
  int              rr = 0;
  logic            pend [NR_PORTS];
  cmo_req_t        payload [NR_PORTS];
  int              p_req, p_rdy, p_ack;
  int              n_cmp = 0;
  int              n_err = 0;
  int              grants [NR_PORTS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic force_ack);
    rst_ni = rst;
    for (int k = 0; k < NR_PORTS; k++) begin
      if (!pend[k] && ($urandom_range(0, 99) < p_req)) begin
        pend[k]             = 1'b1;
        payload[k].req      = 1'b1;
        payload[k].trans_id = TID_W'($urandom);
        payload[k].address  = {$urandom, $urandom};
        payload[k].cmo_op   = cmo_t'($urandom_range(0, 3));
      end
      req_i[k] = pend[k] ? payload[k] : '0;
    end
    cmo_dc_resp_i           = '0;
    cmo_dc_resp_i.req_ready = ($urandom_range(0, 99) < p_rdy);
    if (exp_q.size() > 0) begin
      if (force_ack || ($urandom_range(0, 99) < p_ack)) begin
        cmo_dc_resp_i.ack      = 1'b1;
        cmo_dc_resp_i.trans_id = exp_q[0][TID_W-1:0];
      end
    end else if (force_ack || ($urandom_range(0, 99) < 5)) begin
      cmo_dc_resp_i.ack      = 1'b1;
      cmo_dc_resp_i.trans_id = TID_W'($urandom);
    end
  endtask

  // ---------------- reference model + compare ----------------
  task automatic check_and_step(input logic rst);
    cmo_req_t                 exp_req;
    cmo_resp_t [NR_PORTS-1:0] exp_resp;
    logic                     exp_busy, exp_sp, accept, ack;
    int                       owner, h;
    logic [SB_W-1:0]          head;
    exp_req  = '0;
    exp_resp = '0;
    exp_busy = 1'b0;
    exp_sp   = 1'b0;
    accept   = 1'b0;
    owner    = -1;
    ack      = cmo_dc_resp_i.ack;
    if (rst) begin
      exp_busy = (exp_q.size() > 0) || (lock_port >= 0);
      if (lock_port >= 0) begin
        owner = lock_port;
      end else if (exp_q.size() < MAX_OUT) begin
        for (int i = 0; i < NR_PORTS; i++) begin
          int k;
          k = (rr + i) % NR_PORTS;
          if (owner < 0 && pend[k]) owner = k;
        end
      end
      if (owner >= 0) begin
        exp_req                   = payload[owner];
        exp_resp[owner].req_ready = cmo_dc_resp_i.req_ready;
        accept                    = cmo_dc_resp_i.req_ready;
      end
      if (ack) begin
        if (exp_q.size() > 0) begin
          head                 = exp_q[0];
          h                    = int'(head[SB_W-1:TID_W]);
          exp_resp[h].ack      = 1'b1;
          exp_resp[h].trans_id = cmo_dc_resp_i.trans_id;
        end else begin
          exp_sp = 1'b1;
        end
      end
    end

    check("dc_req",   cmo_dc_req_o,   exp_req);
    check("resp",     resp_o,         exp_resp);
    check("busy",     busy_o,         exp_busy);
    check("spurious", spurious_ack_o, exp_sp);

    if (!rst) begin
      exp_q.delete();
      lock_port = -1;
      rr        = 0;
    end else begin
      if (ack && exp_q.size() > 0) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back({8'(owner), payload[owner].trans_id});
        grants[owner]++;
`ifdef CMO_ARB_FIXED_PRIO_EN
        rr = 0;
`else
        rr = (owner + 1) % NR_PORTS;
`endif
        pend[owner] = 1'b0;
        lock_port   = -1;
      end else if (owner >= 0) begin
        lock_port = owner;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < NR_PORTS; k++) begin
      pend[k]    = 1'b0;
      payload[k] = '0;
      grants[k]  = 0;
    end
    req_i         = '0;
    cmo_dc_resp_i = '0;
    for (int c = 0; c < N_CYC; c++) begin
      logic rst;
      logic fa;
      if (c < 1200)      begin p_req = 50;  p_rdy = 70;  p_ack = 50;  end
      else if (c < 2000) begin p_req = 60;  p_rdy = 90;  p_ack = 10;  end
      else if (c < 2600) begin p_req = 100; p_rdy = 100; p_ack = 100; end
      else if (c < 3000) begin p_req = 70;  p_rdy = 40;  p_ack = 5;   end
      else               begin p_req = 50;  p_rdy = 50;  p_ack = 40;  end
      rst = !((c < 3) || (c == 3000));
      fa  = (c == 3001);
      @(posedge clk);
      #1;
      drive_cycle(rst, fa);
      @(negedge clk);
      check_and_step(rst);
    end
    $display("grants per port: p0=%0d p1=%0d", grants[0], grants[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
